// File: rtl/alu_ctrl_if.sv
// alu_ctrl_if: decode-to-execute control bundle.
// master drives in_valid/opcode/funct/imm/stall/flush and sees in_ready plus the registered controls;
// slave is the ID/EX control stage that produces them.
interface alu_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [15:0]      imm;
    logic             stall;
    logic             flush;
    logic             out_valid;
    logic [3:0]       alu_control;
    logic             alu_src_imm;
    logic [31:0]      imm_ext;
    logic             illegal;
    logic [CNT_W-1:0] illegal_count;
    modport master (
        output in_valid, opcode, funct, imm, stall, flush,
        input  in_ready, out_valid, alu_control, alu_src_imm, imm_ext, illegal, illegal_count
    );
    modport slave (
        input  in_valid, opcode, funct, imm, stall, flush,
        output in_ready, out_valid, alu_control, alu_src_imm, imm_ext, illegal, illegal_count
    );
endinterface

// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage: registered ID/EX generator of the ALU op code, operand-b select and extended immediate.
// Ports: clk, reset (sync, active high), bus (alu_ctrl_if.slave: handshake, opcode/funct/imm in,
// stall/flush in, registered out_valid/alu_control/alu_src_imm/imm_ext/illegal/illegal_count out).
module alu_ctrl_stage #(
    parameter int CNT_W        = 8,
    parameter int TRAP_ILLEGAL = 1
) (
    input logic       clk,
    input logic       reset,
    alu_ctrl_if.slave bus
);
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic       TRAP    = (TRAP_ILLEGAL != 0);

    logic             valid_q, valid_d;
    logic [3:0]       alu_q, alu_d;
    logic             src_q, src_d;
    logic [31:0]      imm_q, imm_d;
    logic             ill_q, ill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             dec_ok;
    logic [3:0]       dec_alu;
    logic             dec_src;
    logic [31:0]      dec_imm;
    logic [31:0]      sext, zext;

    assign sext = {{16{bus.imm[15]}}, bus.imm};
    assign zext = {16'b0, bus.imm};

    always_comb begin
        dec_ok  = 1'b1;
        dec_alu = ALU_ADD;
        dec_src = 1'b0;
        dec_imm = sext;
        case (bus.opcode)
            6'b000000: case (bus.funct)
                6'b100000, 6'b100001: dec_alu = ALU_ADD;
                6'b100010, 6'b100011: dec_alu = ALU_SUB;
                6'b100100:            dec_alu = ALU_AND;
                6'b100101:            dec_alu = ALU_OR;
                6'b100110:            dec_alu = ALU_XOR;
                6'b100111:            dec_alu = ALU_NOR;
                6'b101010, 6'b101011: dec_alu = ALU_SLT;
                default:              dec_ok  = 1'b0;
            endcase
            6'b001000, 6'b001001, 6'b100011, 6'b101011: dec_src = 1'b1;
            6'b001010, 6'b001011: begin dec_alu = ALU_SLT; dec_src = 1'b1; end
            6'b001100: begin dec_alu = ALU_AND; dec_src = 1'b1; dec_imm = zext; end
            6'b001101: begin dec_alu = ALU_OR;  dec_src = 1'b1; dec_imm = zext; end
            6'b001110: begin dec_alu = ALU_XOR; dec_src = 1'b1; dec_imm = zext; end
            6'b000100, 6'b000101: dec_alu = ALU_SUB;
            6'b000010, 6'b000011: dec_imm = '0;
            default: dec_ok = 1'b0;
        endcase
        // Illegal encodings leave the ALU in its neutral ADD/rt/zero configuration.
        if (!dec_ok) begin
            dec_alu = ALU_ADD;
            dec_src = 1'b0;
            dec_imm = '0;
        end
    end

    always_comb begin
        valid_d = valid_q;
        alu_d   = alu_q;
        src_d   = src_q;
        imm_d   = imm_q;
        ill_d   = ill_q;
        cnt_d   = cnt_q;
        if (bus.flush || (!bus.stall && !bus.in_valid)) begin
            valid_d = 1'b0;
            alu_d   = ALU_ADD;
            src_d   = 1'b0;
            imm_d   = '0;
            ill_d   = 1'b0;
        end else if (!bus.stall) begin
            valid_d = dec_ok || TRAP;
            alu_d   = dec_alu;
            src_d   = dec_src;
            imm_d   = dec_imm;
            ill_d   = !dec_ok && TRAP;
            if (!dec_ok && cnt_q != '1)
                cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            alu_q   <= ALU_ADD;
            src_q   <= 1'b0;
            imm_q   <= '0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            alu_q   <= alu_d;
            src_q   <= src_d;
            imm_q   <= imm_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready      = !bus.stall;
    assign bus.out_valid     = valid_q;
    assign bus.alu_control   = alu_q;
    assign bus.alu_src_imm   = src_q;
    assign bus.imm_ext       = imm_q;
    assign bus.illegal       = ill_q;
    assign bus.illegal_count = cnt_q;
endmodule

// File: doc/alu_ctrl_stage.md
Name: alu_ctrl_stage

Overview:
- Registered ID/EX-stage generator of the 4-bit ALU operation code and operand-select controls consumed by the execute-stage ALU.
- Decodes MIPS opcode/funct and extends the 16-bit immediate.
- Provides one-cycle latency with stall (hold) and flush (bubble) semantics, a valid/ready handshake, and an illegal-instruction flag and counter.

Parameters:
- CNT_W, 8, width of the saturating illegal-instruction counter.
- TRAP_ILLEGAL, 1, when 1 an illegal encoding asserts illegal with out_valid=1; when 0 it is silently converted to a bubble (out_valid=0, illegal=0) and still counted.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  decode stage presents an instruction.
- in_ready  output  1  stage accepts this cycle; combinational, equals ~stall.
- opcode  input  6  instruction bits [31:26].
- funct  input  6  instruction bits [5:0].
- imm  input  16  instruction bits [15:0].
- stall  input  1  hazard unit holds the stage.
- flush  input  1  branch/jump squash; inserts a bubble.
- out_valid  output  1  registered outputs carry a real instruction.
- alu_control  output  4  ALU operation code.
- alu_src_imm  output  1  1 selects imm_ext as ALU operand b, 0 selects rt.
- imm_ext  output  32  extended immediate.
- illegal  output  1  registered instruction is an unknown encoding.
- illegal_count  output  CNT_W  saturating count of illegal encodings accepted.

Behaviour:
- Reset values (synchronous, highest priority):
  - out_valid=0, alu_control=4'b0010, alu_src_imm=0, imm_ext=0, illegal=0, illegal_count=0.
- Per-edge priority: reset > flush > stall > load.
  - flush: same values as reset, except illegal_count is unchanged. flush wins over simultaneous stall.
  - stall (no flush): every register holds, including illegal_count. Inputs are ignored.
  - load (no stall, no flush): register the decode of the inputs. If in_valid=0, load a bubble (the reset values, count unchanged).
- Latency: exactly 1 cycle from accepted input to outputs.
- ALU codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, NOR 1100.
- R-type (opcode 000000), alu_src_imm=0. funct decoding:
  - 100000/100001 -> ADD.
  - 100010/100011 -> SUB.
  - 100100 -> AND.
  - 100101 -> OR.
  - 100110 -> XOR.
  - 100111 -> NOR.
  - 101010/101011 -> SLT.
  - Any other funct is illegal.
- I-type, alu_src_imm=1:
  - 001000/001001 (addi/addiu) -> ADD, sign-extend.
  - 001010/001011 (slti/sltiu) -> SLT, sign-extend.
  - 001100 -> AND, zero-extend.
  - 001101 -> OR, zero-extend.
  - 001110 -> XOR, zero-extend.
  - 100011/101011 (lw/sw) -> ADD, sign-extend.
- Branch and jump encodings:
  - 000100/000101 (beq/bne) -> SUB, alu_src_imm=0, imm_ext sign-extended.
  - 000010/000011 (j/jal) -> ADD, alu_src_imm=0, imm_ext=0, legal.
- Extension rules:
  - Sign-extend = {{16{imm[15]}}, imm}; zero-extend = {16'b0, imm}.
  - For R-type, imm_ext = sign-extend of imm (unused downstream).
- Illegal encoding (any opcode/funct not listed):
  - alu_control=0010, alu_src_imm=0, imm_ext=0.
  - TRAP_ILLEGAL=1: out_valid=1, illegal=1.
  - TRAP_ILLEGAL=0: out_valid=0, illegal=0.
- illegal_count:
  - Increments by 1 only on a load cycle with in_valid=1 and an illegal encoding.
  - Saturates at all-ones; no wrap-around.
  - Cleared only by reset.
- Reset asserted together with stall or flush: reset wins and all outputs take their reset values on that edge.

Test Plan:
- Reset 2 cycles, then idle -> out_valid=0, alu_control=0010, illegal_count=0, in_ready=1.
- R-type funct=100111 (nor), in_valid=1 -> next cycle alu_control=1100, alu_src_imm=0, out_valid=1. Repeat with funct=101010 -> alu_control=0111.
- Immediate handling:
  - opcode=001000, imm=16'hFFF0 -> alu_control=0010, alu_src_imm=1, imm_ext=32'hFFFFFFF0.
  - opcode=001101, imm=16'h8001 -> alu_control=0001, imm_ext=32'h00008001.
- Load lw (100011), then stall=1 for 3 cycles while inputs change to andi -> outputs hold the lw values throughout. stall=1 with flush=1 on the next cycle -> out_valid=0.
- opcode=000000, funct=001100, TRAP_ILLEGAL=1 -> out_valid=1, illegal=1, illegal_count=1. Present it 300 times with CNT_W=8 -> illegal_count saturates at 255.
- beq (000100), imm=16'h0004 -> alu_control=0110, alu_src_imm=0. Assert reset in the same cycle as an accepted ori -> next cycle all outputs at reset values.
